// File: rtl/dff_pipe_chain.sv
// Elastic WIDTH x DEPTH register pipeline with per-stage valid bits, valid/ready
// backpressure, bubble collapsing, synchronous flush and an occupancy counter.
module dff_pipe_chain #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0]            validR;
    logic [DEPTH-1:0][WIDTH-1:0] dataR;
    logic [CW-1:0]               occR;
    logic [DEPTH-1:0]            rdyS;
    logic                        acceptS;
    logic                        emitS;

    // Stage readiness: a stage may load when any stage at or beyond it is empty or the consumer takes the last word.
    always_comb begin
        logic holeS;
        holeS = 1'b0;
        rdyS  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            holeS   = holeS | ~validR[i];
            rdyS[i] = holeS | out_ready;
        end
    end

    // Handshake qualifiers for the input and output ports.
    always_comb begin
        in_ready = rdyS[0] & ~flush;
        acceptS  = in_valid & in_ready;
        emitS    = validR[DEPTH-1] & out_ready;
    end

    // Stage registers: each ready stage loads its upstream neighbour, stalled stages hold.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            validR <= '0;
            dataR  <= '0;
        end else if (flush) begin
            validR <= '0;
        end else begin
            if (rdyS[0]) begin
                validR[0] <= in_valid;
                dataR[0]  <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdyS[i]) begin
                    validR[i] <= validR[i-1];
                    dataR[i]  <= dataR[i-1];
                end
            end
        end
    end

    // Occupancy counter; tracks popcount of the valid bits by counting handshakes.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            occR <= '0;
        end else if (flush) begin
            occR <= '0;
        end else begin
            occR <= occR + CW'(acceptS) - CW'(emitS);
        end
    end

    assign out_valid = validR[DEPTH-1];
    assign out_data  = dataR[DEPTH-1];
    assign occupancy = occR;

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Self-checking bench for dff_pipe_chain: queue-based positional model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dff_pipe_chain;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             Clock;
    logic             Resetn;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    occupancy;

    int nChecks = 0;
    int nFail   = 0;
    bit checkOn = 1'b0;

    // Model: words in FIFO order, each with the stage index it occupies.
    int               posQ[$];
    logic [WIDTH-1:0] datQ[$];

    dff_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Resetn(Resetn), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: a word advances when a gap exists ahead of it or the consumer is ready.
    initial begin
        bit acc;
        forever begin
            @(posedge Clock);
            if (!Resetn || flush) begin
                posQ.delete();
                datQ.delete();
            end else begin
                acc = in_valid && (out_ready || posQ.size() < DEPTH);
                for (int k = 0; k < posQ.size(); k++)
                    if (out_ready || k < DEPTH - 1 - posQ[k]) posQ[k]++;
                if (posQ.size() > 0 && posQ[0] == DEPTH) begin
                    void'(posQ.pop_front());
                    void'(datQ.pop_front());
                end
                if (acc) begin
                    posQ.push_back(0);
                    datQ.push_back(in_data);
                end
            end
            if (!Resetn) checkOn = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        bit mValid;
        bit mReady;
        forever begin
            @(negedge Clock);
            if (checkOn) begin
                mValid = posQ.size() > 0 && posQ[0] == DEPTH - 1;
                mReady = !flush && (out_ready || posQ.size() < DEPTH);
                chk("model_out_valid", 32'(out_valid), 32'(mValid));
                if (mValid) chk("model_out_data", 32'(out_data), 32'(datQ[0]));
                chk("model_occupancy", 32'(occupancy), 32'(posQ.size()));
                chk("model_in_ready", 32'(in_ready), 32'(mReady));
                chk("occ_le_depth", 32'(occupancy <= CW'(DEPTH)), 32'd1);
            end
        end
    end

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b0;
        // Reset
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        Resetn = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: single word 2'b10
        drive(1'b1, 2'b10, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("lat_not_early", 32'(out_valid), 32'd0);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", 32'(out_data), 32'd2);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("lat_gone", 32'(out_valid), 32'd0);

        // Streaming 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) drive(1'b1, 2'(i % 4), 1'b1, 1'b0);
        chk("stream_occ", 32'(occupancy), 32'd4);
        chk("stream_data2", 32'(out_data), 32'd2);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("stream_data3", 32'(out_data), 32'd3);
        for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("stream_drained", 32'(occupancy), 32'd0);

        // Backpressure and bubble collapse
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        chk("bp_full_occ", 32'(occupancy), 32'd4);
        chk("bp_full_not_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp_ready_on_drain", 32'(in_ready), 32'd1);
        chk("bp_drain0", 32'(out_data), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("bp_drain1", 32'(out_data), 32'd2);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("bp_drain2", 32'(out_data), 32'd3);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("bp_drain3", 32'(out_data), 32'd0);
        chk("bp_drain3_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Full pass-through
        for (int i = 0; i < 4; i++) drive(1'b1, 2'((i + 1) % 4), 1'b0, 1'b0);
        chk("pt_fill_occ", 32'(occupancy), 32'd4);
        in_valid = 1'b1; in_data = 2'd2; out_ready = 1'b1;
        #1;
        chk("pt_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        chk("pt_occ_a", 32'(occupancy), 32'd4);
        chk("pt_data_a", 32'(out_data), 32'd2);
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        chk("pt_occ_b", 32'(occupancy), 32'd4);
        chk("pt_data_b", 32'(out_data), 32'd3);
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Flush with occupancy 3
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        chk("fl_occ3", 32'(occupancy), 32'd3);
        in_valid = 1'b1; in_data = 2'd0; flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 2'd0, 1'b0, 1'b1);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_occ0", 32'(occupancy), 32'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("fl_nothing_out", 32'(out_valid), 32'd0);

        // Reset mid-operation
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("mr_occ2", 32'(occupancy), 32'd2);
        Resetn = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        Resetn = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_data", 32'(out_data), 32'd0);
        chk("mr_occ", 32'(occupancy), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("mr_nothing_out", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/dff_pipe_chain.md
Name: dff_pipe_chain

Overview:
- Parametrised successor to the per-bit D flip-flop register: a WIDTH-bit, DEPTH-stage register pipeline with a per-stage valid bit, valid/ready backpressure, bubble collapsing and synchronous flush.
- Sits between a producer and a consumer. It provides a fixed minimum latency plus elastic stall absorption of up to DEPTH words.

Parameters:
- WIDTH, 2, data bits per stage (>=1).
- DEPTH, 4, number of register stages (>=1).
- CW, $clog2(DEPTH+1), occupancy counter width. Derived; do not override.

Ports:
- Clock, input, 1, rising-edge clock.
- Resetn, input, 1, synchronous active-low reset.
- flush, input, 1, synchronous clear of all stage valid bits.
- in_valid, input, 1, producer presents in_data.
- in_data, input, WIDTH, input word.
- in_ready, output, 1, pipeline accepts in_data this cycle.
- out_valid, output, 1, last stage holds a word.
- out_data, output, WIDTH, last-stage word.
- out_ready, input, 1, consumer takes out_data this cycle.
- occupancy, output, CW, number of valid stages.

Behaviour:
- State:
  - v[i] is the valid bit and d[i] the data register for stage i, i=0..DEPTH-1.
  - Stage 0 is the input stage. Stage DEPTH-1 drives out_valid=v[DEPTH-1] and out_data=d[DEPTH-1].
- Reset (Resetn=0 at a rising edge):
  - All v=0, all d=0, occupancy=0.
  - After reset: out_valid=0, out_data=0, in_ready=1.
  - Reset overrides flush and all handshakes. Reset mid-transfer discards every word.
- Stage readiness (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - rdy[i] = !v[i] | rdy[i+1] for i<DEPTH-1.
  - in_ready = rdy[0] & !flush.
  - in_ready may depend combinationally on out_ready; this path is intentional.
- Per clock edge, when not in reset and not flushing:
  - Stage i with rdy[i]=1 loads from the stage before it: stage 0 loads in_data with valid in_valid; stage i>0 loads d[i-1] with valid v[i-1].
  - Stage i with rdy[i]=0 holds both data and valid.
  - Bubbles therefore collapse: a stalled output still lets upstream words advance into empty stages.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Emit occurs when out_valid & out_ready.
  - Data presented with in_valid=0 never becomes valid.
- Latency: a word accepted at edge t with no stalls is on out_data with out_valid=1 after edge t+DEPTH-1. DEPTH=1 gives a single register.
- Throughput: one word per cycle while out_ready=1.
- Ordering: strict FIFO. Words are never dropped or duplicated.
- Full condition:
  - All v=1 and out_ready=0 gives in_ready=0.
  - All v=1 and out_ready=1 gives in_ready=1; accept and emit occur in the same cycle.
- Flush (flush=1 at an edge, Resetn=1):
  - All v cleared, occupancy=0, d registers hold their values.
  - No accept that cycle: in_ready=0.
  - An emit that cycle still counts as a completed handshake if out_valid & out_ready; the consumer owns that word.
- Occupancy:
  - Registered counter.
  - next = occ + accept - emit. Simultaneous accept and emit leaves it unchanged.
  - Flush or reset sets it to 0.
  - It must always equal popcount(v). It never exceeds DEPTH and never underflows.

Test Plan:
- Reset/latency, WIDTH=2, DEPTH=4: Resetn=0 for 2 cycles gives out_valid=0, out_data=0, occupancy=0, in_ready=1. Then out_ready=1 and a single accept of in_data=2'b10 at edge t gives out_valid=1, out_data=2'b10 after edge t+3, and out_valid=0 one cycle later.
- Streaming: send 0,1,2,3,0,1 on consecutive cycles with out_ready=1. Outputs appear in the same order starting 3 cycles after the first accept, back-to-back. occupancy settles at 3 or 4 and never exceeds 4.
- Backpressure/bubble collapse: out_ready=0, send 1 word, idle 2 cycles, then send 3 more. After 4 accepts in_ready=0 and occupancy=4. Raising out_ready drains 1,2,3,0 in order, one per cycle; in_ready=1 in the first drain cycle.
- Full pass-through: all stages valid, out_ready=1, in_valid=1. Accept and emit occur in the same cycle, occupancy stays at 4, in_ready=1.
- Flush: occupancy=3, assert flush one cycle with in_valid=1. Next cycle out_valid=0 and occupancy=0; in_ready=0 during the flush cycle; the flushed words never appear at the output.
- Reset mid-operation: occupancy=2 and out_ready=0, pull Resetn low for 1 edge. All outputs return to reset values and no old words emerge afterwards.
